alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
Parametrised multi-cycle integer execution unit for the datapath. It decodes `funct`/`ALUop` with the same operation map as the existing ALU control decode. It executes add/sub/move/swap in one cycle and unsigned multiply/divide iteratively, one bit per cycle. It has a valid/ready handshake on both sides, so the control FSM can stall on long operations.

Parameters:
- WIDTH, 8: operand width in bits; legal range ≥2.
- CNT_W, $clog2(WIDTH+1): width of the iteration counter; derived, do not override.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request (state IDLE).
- ALUop  in  2  op class; only 2'b11 is an ALU operation.
- funct  in  4  function code.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result registers hold a result.
- out_ready  in  1  consumer takes the result.
- res_lo  out  WIDTH  primary result.
- res_hi  out  WIDTH  secondary result.
- flag_zero  out  1  res_lo == 0.
- flag_carry  out  1  add carry-out / sub borrow.
- flag_dz  out  1  divide by zero.
- flag_illegal  out  1  undefined funct or ALUop != 2'b11.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs and flags are 0, counter=0, internal operand regs=0. `in_ready` is 1 as soon as rst_n is released.
- States: IDLE, MUL, DIV, DONE.
- `in_ready` = (state==IDLE). Accept = in_valid & in_ready, sampled at edge T. Operands are captured at T. Inputs are ignored in all other states.
- Decode (ALUop==2'b11):
  - 0000 add: res_lo=(a+b) mod 2^WIDTH; carry=carry-out; res_hi=0.
  - 0010 sub: res_lo=(a-b) mod 2^WIDTH; carry=(a<b); res_hi=0.
  - 0100 mult: {res_hi,res_lo}=a*b, unsigned.
  - 0101 div: res_lo=a/b, res_hi=a%b, unsigned.
  - 0111 move: res_lo=a, res_hi=0.
  - 1000 swap: res_lo=b, res_hi=a.
  - Any other funct, or ALUop!=2'b11: res_lo=res_hi=0, flag_illegal=1.
- Single-cycle ops (add, sub, move, swap, illegal): IDLE→DONE at T. Result and flags are registered at T, so out_valid=1 from cycle T+1.
- Mult: IDLE→MUL at T, counter=WIDTH. Shift-add one bit per cycle. After WIDTH iterations go to DONE; out_valid=1 from cycle T+WIDTH+1.
- Div:
  - If b==0: IDLE→DONE at T with res_lo=all ones, res_hi=a, flag_dz=1; out_valid at T+1.
  - Otherwise IDLE→DIV. Restoring division, one quotient bit per cycle, WIDTH iterations; out_valid at T+WIDTH+1.
- res_lo, res_hi and flags change only on the transition into DONE, and are held stable while out_valid=1.
- DONE: out_valid=1. If out_ready=1 at an edge: DONE→IDLE and out_valid falls; res_* and flags keep their values. in_ready rises in the same cycle out_valid falls.
  - No accept in the cycle the result is taken. Minimum issue interval is 2 cycles.
- Flags:
  - flag_zero computed from the final res_lo for every op.
  - flag_carry is 0 for all ops except add/sub.
  - flag_dz is 0 except div by zero.
  - Every new result overwrites all flags.
- Counter: decrements once per MUL/DIV cycle; the transition to DONE occurs on the edge where counter==1. No wrap-around.
- Reset asserted mid-MUL/DIV/DONE: the operation is abandoned with no result and all outputs clear immediately (asynchronously).
- out_ready while not out_valid: ignored.

Test Plan:
- WIDTH=8; add a=0xF0, b=0x20 accepted at T → out_valid at T+1, res_lo=0x10, res_hi=0x00, carry=1, zero=0. Then sub a=0x10, b=0x20 → res_lo=0xF0, carry=1.
- mult a=200, b=150 at T → in_ready=0 for T+1..T+9; out_valid first at T+9; res_hi=0x75, res_lo=0x30. Second in_valid pulse during MUL is ignored.
- div a=200, b=7 → out_valid at T+9, res_lo=28, res_hi=4, dz=0. Then div a=0x55, b=0 → out_valid at T+1, res_lo=0xFF, res_hi=0x55, dz=1.
- swap a=0x12, b=0x34 with out_ready held 0 for 5 cycles → res_lo=0x34, res_hi=0x12 held stable, out_valid=1 and in_ready=0 throughout. Raising out_ready gives out_valid=0 and in_ready=1 next cycle.
- ALUop=2'b10 funct=0000, then ALUop=2'b11 funct=1111 → both give illegal=1, res_lo=0, zero=1, latency 1. Move a=0x00 → zero=1, illegal=0.
- Start mult, assert rst_n=0 at iteration 4 → all outputs 0 immediately. After release, in_ready=1 and a fresh add 3+4 gives res_lo=7.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Multi-cycle integer execution unit: single-cycle add/sub/move/swap, iterative
// unsigned shift-add multiply and restoring divide, valid/ready on both sides.
module alu_exec_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ALUop,
    input  logic [3:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_dz,
    output logic             flag_illegal
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   whi_q, whi_d;
    logic [WIDTH-1:0]   wlo_q, wlo_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               dz_q, dz_d;
    logic               ill_q, ill_d;

    logic               load;
    logic [WIDTH-1:0]   n_lo, n_hi;
    logic               n_carry, n_dz, n_ill;
    logic [WIDTH:0]     add_sum, mac_sum, div_sh;
    logic [2*WIDTH-1:0] mul_nxt;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opb_d   = opb_q;
        whi_d   = whi_q;
        wlo_d   = wlo_q;
        load    = 1'b0;
        n_lo    = '0;
        n_hi    = '0;
        n_carry = 1'b0;
        n_dz    = 1'b0;
        n_ill   = 1'b0;

        add_sum = {1'b0, a} + {1'b0, b};
        // Multiply: whi holds the running partial product, wlo the unconsumed multiplier bits.
        mac_sum = {1'b0, whi_q} + {1'b0, opb_q};
        mul_nxt = wlo_q[0] ? {mac_sum, wlo_q[WIDTH-1:1]}
                           : {1'b0, whi_q, wlo_q[WIDTH-1:1]};
        // Divide: whi is the partial remainder, wlo shifts dividend out and quotient in.
        div_sh  = {whi_q, wlo_q[WIDTH-1]};
        div_ge  = (div_sh >= {1'b0, opb_q});
        div_rem = div_ge ? WIDTH'(div_sh - {1'b0, opb_q}) : div_sh[WIDTH-1:0];

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_DONE;
                    load    = 1'b1;
                    if (ALUop != 2'b11) begin
                        n_ill = 1'b1;
                    end else begin
                        case (funct)
                            4'b0000: begin
                                n_lo    = add_sum[WIDTH-1:0];
                                n_carry = add_sum[WIDTH];
                            end
                            4'b0010: begin
                                n_lo    = a - b;
                                n_carry = (a < b);
                            end
                            4'b0100: begin
                                state_d = S_MUL;
                                load    = 1'b0;
                                cnt_d   = CNT_W'(WIDTH);
                                opb_d   = a;
                                whi_d   = '0;
                                wlo_d   = b;
                            end
                            4'b0101: begin
                                if (b == '0) begin
                                    n_lo = '1;
                                    n_hi = a;
                                    n_dz = 1'b1;
                                end else begin
                                    state_d = S_DIV;
                                    load    = 1'b0;
                                    cnt_d   = CNT_W'(WIDTH);
                                    opb_d   = b;
                                    whi_d   = '0;
                                    wlo_d   = a;
                                end
                            end
                            4'b0111: n_lo = a;
                            4'b1000: begin
                                n_lo = b;
                                n_hi = a;
                            end
                            default: n_ill = 1'b1;
                        endcase
                    end
                end
            end
            S_MUL: begin
                {whi_d, wlo_d} = mul_nxt;
                cnt_d          = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d      = S_DONE;
                    load         = 1'b1;
                    {n_hi, n_lo} = mul_nxt;
                end
            end
            S_DIV: begin
                whi_d = div_rem;
                wlo_d = {wlo_q[WIDTH-2:0], div_ge};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                    load    = 1'b1;
                    n_lo    = {wlo_q[WIDTH-2:0], div_ge};
                    n_hi    = div_rem;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        res_lo_d = load ? n_lo : res_lo_q;
        res_hi_d = load ? n_hi : res_hi_q;
        zero_d   = load ? (n_lo == '0) : zero_q;
        carry_d  = load ? n_carry : carry_q;
        dz_d     = load ? n_dz : dz_q;
        ill_d    = load ? n_ill : ill_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            opb_q    <= '0;
            whi_q    <= '0;
            wlo_q    <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            dz_q     <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opb_q    <= opb_d;
            whi_q    <= whi_d;
            wlo_q    <= wlo_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            dz_q     <= dz_d;
            ill_q    <= ill_d;
        end
    end

    assign in_ready     = (state_q == S_IDLE);
    assign out_valid    = (state_q == S_DONE);
    assign res_lo       = res_lo_q;
    assign res_hi       = res_hi_q;
    assign flag_zero    = zero_q;
    assign flag_carry   = carry_q;
    assign flag_dz      = dz_q;
    assign flag_illegal = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized self-checking bench for alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   ALUop = 2'b00;
    logic [3:0]   funct = 4'b0000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] res_lo, res_hi;
    logic         flag_zero, flag_carry, flag_dz, flag_illegal;

    int unsigned errors = 0;
    int unsigned checks = 0;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALUop(ALUop), .funct(funct), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .res_lo(res_lo), .res_hi(res_hi), .flag_zero(flag_zero),
        .flag_carry(flag_carry), .flag_dz(flag_dz), .flag_illegal(flag_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model(input logic [1:0] op, input logic [3:0] fn,
                         input int unsigned x, input int unsigned y,
                         output int unsigned lo, output int unsigned hi,
                         output int unsigned cy, output int unsigned dz,
                         output int unsigned ill, output int unsigned lat);
        int unsigned m;
        m = (1 << W) - 1;
        lo = 0; hi = 0; cy = 0; dz = 0; ill = 0; lat = 1;
        if (op != 2'b11) ill = 1;
        else case (fn)
            4'd0: begin lo = (x + y) & m; cy = (x + y) >> W; end
            4'd2: begin lo = (x + (1 << W) - y) & m; cy = (x < y) ? 1 : 0; end
            4'd4: begin lo = (x * y) & m; hi = (x * y) >> W; lat = W + 1; end
            4'd5: begin
                if (y == 0) begin lo = m; hi = x; dz = 1; end
                else begin lo = x / y; hi = x % y; lat = W + 1; end
            end
            4'd7: lo = x;
            4'd8: begin lo = y; hi = x; end
            default: ill = 1;
        endcase
    endtask

    task automatic run_op(input logic [1:0] op, input logic [3:0] fn,
                          input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input int hold, input bit poke);
        int unsigned e_lo, e_hi, e_cy, e_dz, e_ill, e_lat;
        int unsigned lat;
        model(op, fn, ai, bi, e_lo, e_hi, e_cy, e_dz, e_ill, e_lat);
        check("idle_in_ready", 32'(in_ready), 1);
        in_valid = 1'b1; ALUop = op; funct = fn; a = ai; b = bi;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            check("busy_in_ready", 32'(in_ready), 0);
            if (poke && lat == 3) begin
                in_valid = 1'b1; ALUop = 2'b11; funct = 4'b0000;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat++;
        end
        check("latency", lat, e_lat);
        check("res_lo", 32'(res_lo), e_lo);
        check("res_hi", 32'(res_hi), e_hi);
        check("zero", 32'(flag_zero), (e_lo == 0) ? 1 : 0);
        check("carry", 32'(flag_carry), e_cy);
        check("dz", 32'(flag_dz), e_dz);
        check("illegal", 32'(flag_illegal), e_ill);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 1);
            check("hold_in_ready", 32'(in_ready), 0);
            check("hold_lo", 32'(res_lo), e_lo);
            check("hold_hi", 32'(res_hi), e_hi);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("taken_valid", 32'(out_valid), 0);
        check("taken_in_ready", 32'(in_ready), 1);
        check("taken_lo_kept", 32'(res_lo), e_lo);
    endtask

    initial begin
        logic [3:0] fsel [7];
        fsel = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd7, 4'd8, 4'd15};

        #12;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_lo", 32'(res_lo), 0);
        check("rst_hi", 32'(res_hi), 0);
        check("rst_flags", {28'd0, flag_zero, flag_carry, flag_dz, flag_illegal}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(in_ready), 1);

        run_op(2'b11, 4'b0000, 8'hF0, 8'h20, 0, 1'b0);
        run_op(2'b11, 4'b0010, 8'h10, 8'h20, 0, 1'b0);
        run_op(2'b11, 4'b0100, 8'd200, 8'd150, 1, 1'b1);
        run_op(2'b11, 4'b0101, 8'd200, 8'd7, 0, 1'b1);
        run_op(2'b11, 4'b0101, 8'h55, 8'h00, 0, 1'b0);
        run_op(2'b11, 4'b1000, 8'h12, 8'h34, 5, 1'b0);
        run_op(2'b10, 4'b0000, 8'h01, 8'h02, 0, 1'b0);
        run_op(2'b11, 4'b1111, 8'h01, 8'h02, 0, 1'b0);
        run_op(2'b11, 4'b0111, 8'h00, 8'h09, 0, 1'b0);
        run_op(2'b11, 4'b0100, 8'hFF, 8'hFF, 0, 1'b0);
        run_op(2'b11, 4'b0101, 8'hFF, 8'h01, 0, 1'b0);
        run_op(2'b11, 4'b0000, 8'h80, 8'h80, 0, 1'b0);
        run_op(2'b11, 4'b0010, 8'h20, 8'h20, 0, 1'b0);

        for (int n = 0; n < 80; n++) begin
            logic [1:0]   op;
            logic [3:0]   fn;
            logic [W-1:0] x, y;
            op = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            fn = ($urandom_range(0, 9) == 0) ? 4'($urandom) : fsel[$urandom_range(0, 6)];
            x  = W'($urandom);
            y  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            run_op(op, fn, x, y, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        in_valid = 1'b1; ALUop = 2'b11; funct = 4'b0100; a = 8'd13; b = 8'd11;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(out_valid), 0);
        check("abort_lo", 32'(res_lo), 0);
        check("abort_hi", 32'(res_hi), 0);
        check("abort_flags", {28'd0, flag_zero, flag_carry, flag_dz, flag_illegal}, 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_in_ready", 32'(in_ready), 1);
        run_op(2'b11, 4'b0000, 8'd3, 8'd4, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
